clk_divider_multi: RTL



---
 rtl/clk_div_pkg.sv | 26 ++
 rtl/clk_div_channel.sv | 100 ++++++++++
 rtl/clk_divider_multi.sv | 48 ++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants, channel mode encoding and divisor helpers for the
// multi-channel synchronous clock divider.
package clk_div_pkg;

  localparam int unsigned DIV_W_DEF   = 8;
  localparam int unsigned NUM_CH_DEF  = 4;
  localparam int unsigned DIV_RST_DEF = 2;

  typedef enum logic [1:0] {
    CH_OFF   = 2'd0,
    CH_EVERY = 2'd1,
    CH_DIV   = 2'd2
  } ch_mode_e;

  // ceil(d/2), one bit wider than the operand so d = all-ones cannot wrap.
  function automatic logic [32:0] div_half_up(input logic [31:0] d);
    return ({1'b0, d} + 33'd1) >> 1;
  endfunction

  function automatic ch_mode_e div_mode(input logic [31:0] d);
    if (d == 32'd0) return CH_OFF;
    if (d == 32'd1) return CH_EVERY;
    return CH_DIV;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter with active/shadow divisor, registered
// divided clock and per-period tick. Ratio changes land only on period boundaries.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic             clk_hf,
  input  logic             reset,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wdata_i,
  input  logic             sync_i,
  output logic             clk_div_o,
  output logic             tick_o,
  output logic             pend_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             at_bnd;
  logic             restart;
  logic [DIV_W:0]   half_d;
  ch_mode_e         mode_d;

  always_comb begin
    at_bnd  = (act_q <= DIV_W'(1)) || (cnt_q == act_q - DIV_W'(1));
    restart = sync_i || at_bnd;
    cnt_d   = cnt_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    if (restart) begin
      cnt_d = '0;
      if (wr_i) begin
        act_d  = wdata_i;
        shd_d  = wdata_i;
        pend_d = 1'b0;
      end else if (pend_q) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
      if (wr_i) begin
        shd_d  = wdata_i;
        pend_d = 1'b1;
      end
    end
  end

  // Outputs are decoded from the next counter/divisor so the flops line up
  // with the counter value of the cycle they are visible in.
  always_comb begin
    mode_d    = div_mode(32'(act_d));
    half_d    = (DIV_W+1)'(div_half_up(32'(act_d)));
    clk_div_d = 1'b0;
    tick_d    = 1'b0;
    if (!sync_i) begin
      case (mode_d)
        CH_EVERY: tick_d = 1'b1;
        CH_DIV: begin
          clk_div_d = ({1'b0, cnt_d} >= half_d);
          tick_d    = (cnt_d == act_d - DIV_W'(1));
        end
        default: begin
          clk_div_d = 1'b0;
          tick_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_hf) begin
    if (reset) begin
      cnt_q     <= '0;
      act_q     <= DIV_W'(DIV_RST);
      shd_q     <= DIV_W'(DIV_RST);
      pend_q    <= 1'b0;
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      pend_q    <= pend_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_div_o = clk_div_q;
  assign tick_o    = tick_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/clk_divider_multi.sv
// N-channel fully synchronous clock divider on clk_hf: config-write decode
// and one clk_div_channel per channel, all sharing the sync restart.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter  int unsigned NUM_CH  = NUM_CH_DEF,
  parameter  int unsigned DIV_W   = DIV_W_DEF,
  parameter  int unsigned DIV_RST = DIV_RST_DEF,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_hf,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] wr;

  // Selects at or above NUM_CH match no channel and are dropped.
  always_comb begin
    wr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr[i] = cfg_we && (32'(cfg_ch) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk_hf    (clk_hf),
      .reset     (reset),
      .wr_i      (wr[g]),
      .wdata_i   (cfg_div),
      .sync_i    (sync),
      .clk_div_o (clk_div[g]),
      .tick_o    (tick[g]),
      .pend_o    (pending[g])
    );
  end

endmodule
